// File: rtl/preg_rename_manager.sv
// rtl/preg_rename_manager.sv - virtual->physical register rename, PRF, ready bits and free list
module preg_rename_manager #(
  parameter int N_VREG = 32,
  parameter int N_PREG = 64,
  parameter int W_VREG = 5,
  parameter int W_PREG = 6,
  parameter int W_WORD = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              rs1_order,
  input  logic [W_VREG-1:0] va_rs1,
  input  logic              rs2_order,
  input  logic [W_VREG-1:0] va_rs2,
  input  logic              rd_order,
  input  logic [W_VREG-1:0] va_rd,
  input  logic              branch_hazard,
  input  logic              w_order,
  input  logic [W_PREG-1:0] w_pa_rd,
  input  logic [W_WORD-1:0] w_d_rd,
  input  logic              free_valid,
  input  logic [W_PREG-1:0] free_pa,
  output logic              out_valid,
  output logic              rs1_ready,
  output logic [W_WORD-1:0] d_rs1,
  output logic              rs2_ready,
  output logic [W_WORD-1:0] d_rs2,
  output logic              rd_ready,
  output logic [W_PREG-1:0] pa_rd,
  output logic [W_PREG-1:0] old_pa_rd,
  output logic              branch_hazard_o,
  output logic              err
);

  localparam int W_CNT = W_PREG + 1;

  logic [W_PREG-1:0] map_q  [N_VREG];
  logic [W_WORD-1:0] prf_q  [N_PREG];
  logic [W_PREG-1:0] fl_q   [N_PREG];
  logic [N_PREG-1:0] rdy_q;
  logic [W_PREG-1:0] head_q;
  logic [W_PREG-1:0] tail_q;
  logic [W_CNT-1:0]  count_q;

  logic              accept;
  logic              pop;
  logic              push_ok;
  logic              overflow;
  logic [W_PREG-1:0] pa1;
  logic [W_PREG-1:0] pa2;
  logic              use1;
  logic              use2;
  logic              byp1;
  logic              byp2;
  logic              rs1_rdy_n;
  logic              rs2_rdy_n;
  logic [W_WORD-1:0] rs1_d_n;
  logic [W_WORD-1:0] rs2_d_n;

  // Handshake: readiness depends only on registered free-list occupancy
  assign req_ready = (count_q != '0);
  assign accept    = req_valid && req_ready;
  assign pop       = accept && rd_order && (va_rd != '0);
  // A full list still takes a push when a pop frees a slot in the same cycle
  assign push_ok   = free_valid && ((count_q != W_CNT'(N_PREG)) || pop);
  assign overflow  = free_valid && !push_ok;

  // Operand lookup against the map as it stood before this request's rd update
  assign pa1       = map_q[va_rs1];
  assign pa2       = map_q[va_rs2];
  assign use1      = rs1_order && (va_rs1 != '0);
  assign use2      = rs2_order && (va_rs2 != '0);
  assign byp1      = w_order && (w_pa_rd == pa1);
  assign byp2      = w_order && (w_pa_rd == pa2);
  assign rs1_rdy_n = !use1 || byp1 || rdy_q[pa1];
  assign rs2_rdy_n = !use2 || byp2 || rdy_q[pa2];
  assign rs1_d_n   = !use1 ? '0 : (byp1 ? w_d_rd : prf_q[pa1]);
  assign rs2_d_n   = !use2 ? '0 : (byp2 ? w_d_rd : prf_q[pa2]);

  // Map table, register file and ready bits; allocation clear overrides writeback set
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_VREG; i++) map_q[i] <= W_PREG'(i);
      for (int i = 0; i < N_PREG; i++) begin
        prf_q[i] <= '0;
        rdy_q[i] <= (i < N_VREG);
      end
    end else begin
      if (w_order) begin
        prf_q[w_pa_rd] <= w_d_rd;
        rdy_q[w_pa_rd] <= 1'b1;
      end
      if (pop) begin
        map_q[va_rd]  <= fl_q[head_q];
        rdy_q[fl_q[head_q]] <= 1'b0;
      end
    end
  end

  // Circular free list; pointers wrap naturally since N_PREG is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_PREG; i++) fl_q[i] <= W_PREG'(i);
      head_q  <= W_PREG'(N_VREG);
      tail_q  <= '0;
      count_q <= W_CNT'(N_PREG - N_VREG);
      err     <= 1'b0;
    end else begin
      if (push_ok) begin
        fl_q[tail_q] <= free_pa;
        tail_q       <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
      if (push_ok && !pop) count_q <= count_q + 1'b1;
      else if (pop && !push_ok) count_q <= count_q - 1'b1;
      if (overflow) err <= 1'b1;
    end
  end

  // Operand record register: pulse out_valid, hold the record otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      rs1_ready       <= 1'b0;
      d_rs1           <= '0;
      rs2_ready       <= 1'b0;
      d_rs2           <= '0;
      rd_ready        <= 1'b0;
      pa_rd           <= '0;
      old_pa_rd       <= '0;
      branch_hazard_o <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        rs1_ready       <= rs1_rdy_n;
        d_rs1           <= rs1_d_n;
        rs2_ready       <= rs2_rdy_n;
        d_rs2           <= rs2_d_n;
        rd_ready        <= !pop;
        pa_rd           <= pop ? fl_q[head_q] : '0;
        old_pa_rd       <= pop ? map_q[va_rd] : '0;
        branch_hazard_o <= branch_hazard;
      end
    end
  end

endmodule

// File: tb/tb_preg_rename_manager.sv
// tb/tb_preg_rename_manager.sv - directed bench with reference model for preg_rename_manager
module tb_preg_rename_manager;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic        rs1_order, rs2_order, rd_order;
  logic [4:0]  va_rs1, va_rs2, va_rd;
  logic        branch_hazard;
  logic        w_order;
  logic [5:0]  w_pa_rd;
  logic [31:0] w_d_rd;
  logic        free_valid;
  logic [5:0]  free_pa;
  logic        out_valid, rs1_ready, rs2_ready, rd_ready, branch_hazard_o, err;
  logic [31:0] d_rs1, d_rs2;
  logic [5:0]  pa_rd, old_pa_rd;

  int n_vec = 0;
  int n_err = 0;

  preg_rename_manager dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .rs1_order(rs1_order), .va_rs1(va_rs1), .rs2_order(rs2_order), .va_rs2(va_rs2),
    .rd_order(rd_order), .va_rd(va_rd), .branch_hazard(branch_hazard),
    .w_order(w_order), .w_pa_rd(w_pa_rd), .w_d_rd(w_d_rd),
    .free_valid(free_valid), .free_pa(free_pa),
    .out_valid(out_valid), .rs1_ready(rs1_ready), .d_rs1(d_rs1),
    .rs2_ready(rs2_ready), .d_rs2(d_rs2), .rd_ready(rd_ready),
    .pa_rd(pa_rd), .old_pa_rd(old_pa_rd), .branch_hazard_o(branch_hazard_o), .err(err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arrays and a queue for the free list
  int          m_map [32];
  bit          m_rdy [64];
  logic [31:0] m_prf [64];
  int          m_fl  [$];
  bit          m_err;
  bit          model_live = 0;
  bit          e_valid, e_rs1_rdy, e_rs2_rdy, e_rd_rdy, e_bh;
  logic [31:0] e_d1, e_d2;
  int          e_pa, e_old;

  function automatic void lookup(input bit order, input int va, output bit rdy, output logic [31:0] d);
    int pa;
    if (!order || va == 0) begin
      rdy = 1; d = 0;
    end else begin
      pa = m_map[va];
      if (w_order && int'(w_pa_rd) == pa) begin
        rdy = 1; d = w_d_rd;
      end else begin
        rdy = m_rdy[pa]; d = m_prf[pa];
      end
    end
  endfunction

  // Model state update at each active edge from the stable inputs
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_map[i] = i;
      for (int i = 0; i < 64; i++) begin
        m_rdy[i] = (i < 32);
        m_prf[i] = 0;
      end
      m_fl.delete();
      for (int i = 32; i < 64; i++) m_fl.push_back(i);
      m_err = 0;
      e_valid = 0; e_rs1_rdy = 0; e_rs2_rdy = 0; e_rd_rdy = 0; e_bh = 0;
      e_d1 = 0; e_d2 = 0; e_pa = 0; e_old = 0;
      model_live = 1;
    end else if (model_live) begin
      bit acc, do_pop;
      int hd;
      acc    = req_valid && (m_fl.size() != 0);
      do_pop = acc && rd_order && (va_rd != 0);
      e_valid = acc;
      if (acc) begin
        lookup(rs1_order, int'(va_rs1), e_rs1_rdy, e_d1);
        lookup(rs2_order, int'(va_rs2), e_rs2_rdy, e_d2);
        e_bh = branch_hazard;
        if (do_pop) begin
          e_pa = m_fl[0]; e_old = m_map[va_rd]; e_rd_rdy = 0;
        end else begin
          e_pa = 0; e_old = 0; e_rd_rdy = 1;
        end
      end
      if (w_order) begin
        m_prf[w_pa_rd] = w_d_rd;
        m_rdy[w_pa_rd] = 1;
      end
      if (do_pop) begin
        hd = m_fl.pop_front();
        m_map[va_rd] = hd;
        m_rdy[hd] = 0;
      end
      if (free_valid) begin
        if (m_fl.size() < 64) m_fl.push_back(int'(free_pa));
        else m_err = 1;
      end
    end
  end

  // Compare DUT against model every cycle, away from the active edge
  always @(negedge clk) begin
    if (model_live && !rst) begin
      chk("m_out_valid", 32'(out_valid), 32'(e_valid));
      chk("m_req_ready", 32'(req_ready), 32'(m_fl.size() != 0));
      chk("m_err", 32'(err), 32'(m_err));
      chk("m_rs1_ready", 32'(rs1_ready), 32'(e_rs1_rdy));
      chk("m_rs2_ready", 32'(rs2_ready), 32'(e_rs2_rdy));
      if (e_rs1_rdy) chk("m_d_rs1", d_rs1, e_d1);
      if (e_rs2_rdy) chk("m_d_rs2", d_rs2, e_d2);
      chk("m_rd_ready", 32'(rd_ready), 32'(e_rd_rdy));
      chk("m_pa_rd", 32'(pa_rd), 32'(e_pa));
      chk("m_old_pa_rd", 32'(old_pa_rd), 32'(e_old));
      chk("m_bh", 32'(branch_hazard_o), 32'(e_bh));
    end
  end

  task automatic idle();
    req_valid = 0; rs1_order = 0; va_rs1 = 0; rs2_order = 0; va_rs2 = 0;
    rd_order = 0; va_rd = 0; branch_hazard = 0;
    w_order = 0; w_pa_rd = 0; w_d_rd = 0; free_valid = 0; free_pa = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    idle();
  endtask

  task automatic req(input bit o1, input int v1, input bit o2, input int v2, input bit od, input int vd);
    req_valid = 1;
    rs1_order = o1; va_rs1 = 5'(v1);
    rs2_order = o2; va_rs2 = 5'(v2);
    rd_order  = od; va_rd  = 5'(vd);
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle();
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_err", 32'(err), 0);
    chk("rst_pa_rd", 32'(pa_rd), 0);

    // 1: first allocation
    req(1, 3, 1, 5, 1, 7); branch_hazard = 1; tick();
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_rs1_ready", 32'(rs1_ready), 1);
    chk("t1_d_rs1", d_rs1, 0);
    chk("t1_rs2_ready", 32'(rs2_ready), 1);
    chk("t1_pa_rd", 32'(pa_rd), 32);
    chk("t1_old_pa_rd", 32'(old_pa_rd), 7);
    chk("t1_rd_ready", 32'(rd_ready), 0);
    chk("t1_bh", 32'(branch_hazard_o), 1);
    tick();
    chk("t1_pulse", 32'(out_valid), 0);
    chk("t1_hold", 32'(pa_rd), 32);

    // 2: not-ready operand, bypass, then from register file
    req(1, 7, 0, 0, 0, 0); tick();
    chk("t2_not_ready", 32'(rs1_ready), 0);
    req(1, 7, 0, 0, 0, 0); w_order = 1; w_pa_rd = 32; w_d_rd = 32'hDEADBEEF; tick();
    chk("t2_byp_ready", 32'(rs1_ready), 1);
    chk("t2_byp_d", d_rs1, 32'hDEADBEEF);
    chk("t2_rd_ready", 32'(rd_ready), 1);
    chk("t2_pa_rd_zero", 32'(pa_rd), 0);
    req(0, 0, 1, 7, 0, 0); tick();
    chk("t2_prf_ready", 32'(rs2_ready), 1);
    chk("t2_prf_d", d_rs2, 32'hDEADBEEF);

    // 3: source and destination on the same virtual register
    req(1, 9, 0, 0, 1, 9); tick();
    chk("t3_rs1_ready", 32'(rs1_ready), 1);
    chk("t3_pa_rd", 32'(pa_rd), 33);
    chk("t3_old_pa_rd", 32'(old_pa_rd), 9);

    // 5: rd to va0 allocates nothing; pop with simultaneous free
    req(0, 0, 0, 0, 1, 0); tick();
    chk("t5_rd_ready", 32'(rd_ready), 1);
    chk("t5_pa_rd", 32'(pa_rd), 0);
    chk("t5_old", 32'(old_pa_rd), 0);
    req(0, 0, 0, 0, 1, 11); free_valid = 1; free_pa = 9; tick();
    chk("t5_popfree_pa", 32'(pa_rd), 34);

    // Mixed traffic against the model
    for (int i = 0; i < 24; i++) begin
      req(1, i % 32, 1, (i * 7) % 32, (i % 3) != 0, (i * 5) % 32);
      branch_hazard = i[0];
      if (i % 2 == 1) begin
        w_order = 1; w_pa_rd = 6'(32 + (i % 8)); w_d_rd = 32'(i * 32'h1111);
      end
      if (i % 4 == 0) begin
        free_valid = 1; free_pa = 6'(40 + i);
      end
      tick();
    end

    // 4: drain the free list, then refill with one entry
    do_reset();
    for (int i = 0; i < 32; i++) begin
      req(0, 0, 0, 0, 1, (i % 31) + 1);
      tick();
    end
    chk("t4_last_pa", 32'(pa_rd), 63);
    chk("t4_empty", 32'(req_ready), 0);
    req(1, 1, 0, 0, 1, 2); free_valid = 1; free_pa = 7; tick();
    chk("t4_no_bypass", 32'(out_valid), 0);
    chk("t4_refilled", 32'(req_ready), 1);
    req(0, 0, 0, 0, 1, 2); tick();
    chk("t4_pa_rd", 32'(pa_rd), 7);
    chk("t4_old", 32'(old_pa_rd), 33);

    // 6: overflow and mid-operation reset
    do_reset();
    for (int i = 0; i < 33; i++) begin
      free_valid = 1; free_pa = 6'(i);
      tick();
      if (i == 31) chk("t6_full_no_err", 32'(err), 0);
    end
    chk("t6_err", 32'(err), 1);
    req(1, 7, 0, 0, 1, 7); free_valid = 1; free_pa = 3; rst = 1; tick();
    rst = 0;
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_err", 32'(err), 0);
    chk("t6_rst_ready", 32'(req_ready), 1);
    req(1, 7, 0, 0, 1, 7); tick();
    chk("t6_map_rdy", 32'(rs1_ready), 1);
    chk("t6_map_old", 32'(old_pa_rd), 7);
    chk("t6_map_pa", 32'(pa_rd), 32);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
